fp_mult_seq: RTL and testbench

- Parametrised sequential IEEE-754-style floating-point multiplier; next generation of the team's fixed 32-bit FP multiplier.
- Formats are selectable by exponent/mantissa width. Mantissas are multiplied with an iterative shift-add datapath, one bit per cycle.
- Adds full special-case handling, round-to-nearest-even, a busy/done handshake and an inexact flag.
- Sits behind the FP unit dispatcher, one operation in flight at a time.

---
 rtl/fp_mult_seq.sv | 177 +++++++++++++++++
 tb/tb_fp_mult_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_seq.sv
// Iterative IEEE-754 multiplier: shift-add mantissa product one bit per cycle, RNE rounding, denormals flushed.
// Latency MAN_W+3 cycles from accepted start (2 for special operands); start_i is ignored while busy_o is high.
module fp_mult_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [EXP_W+MAN_W:0] a_i,
    input  logic [EXP_W+MAN_W:0] b_i,
    output logic [EXP_W+MAN_W:0] product_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 nan_o,
    output logic                 infinit_o,
    output logic                 overflow_o,
    output logic                 underflow_o,
    output logic                 inexact_o
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int PW   = 2 * MAN_W + 2;
    localparam int CW   = $clog2(MAN_W + 1) + 1;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int EMAX = (1 << EXP_W) - 1;
    localparam logic [EXP_W+1:0] BIAS_X = (EXP_W + 2)'(BIAS);
    localparam logic [EXP_W+1:0] EMAX_X = (EXP_W + 2)'(EMAX);
    localparam logic [EXP_W-1:0] EMAX_F = '1;
    localparam logic [W-1:0]     QNAN   = {1'b0, EMAX_F, 1'b1, {(MAN_W - 1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_MULT, S_ROUND, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [W-1:0]     r_a, r_b;
    logic [MAN_W:0]   r_hi, r_lo, r_ma;
    logic [CW-1:0]    r_cnt;
    logic [EXP_W+1:0] r_exp;
    logic             r_sign, r_special, r_spec_nan, r_spec_inf;
    logic [W-1:0]     r_spec_res;
    logic [W-1:0]     r_product;
    logic             r_nan, r_inf, r_ovf, r_unf, r_inex;

    // Operand classification, evaluated in UNPACK
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_fa, w_fb;
    logic             w_sign, w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic             w_is_nan, w_is_inf, w_special;

    assign w_ea      = r_a[W-2 -: EXP_W];
    assign w_eb      = r_b[W-2 -: EXP_W];
    assign w_fa      = r_a[MAN_W-1:0];
    assign w_fb      = r_b[MAN_W-1:0];
    assign w_sign    = r_a[W-1] ^ r_b[W-1];
    assign w_a_zero  = (w_ea == '0);
    assign w_b_zero  = (w_eb == '0);
    assign w_a_inf   = (w_ea == EMAX_F) && (w_fa == '0);
    assign w_b_inf   = (w_eb == EMAX_F) && (w_fb == '0);
    assign w_a_nan   = (w_ea == EMAX_F) && (w_fa != '0);
    assign w_b_nan   = (w_eb == EMAX_F) && (w_fb != '0);
    assign w_is_nan  = w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero);
    assign w_is_inf  = w_a_inf | w_b_inf;
    assign w_special = w_is_nan | w_is_inf | w_a_zero | w_b_zero;

    // Shift-add step: accumulate into the upper half, shift the multiplier out of the lower half
    logic [MAN_W+1:0] w_sum;
    assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_ma} : '0);

    // Normalise, round to nearest even, range check
    logic [PW-1:0]    w_p;
    logic             w_msb, w_g, w_s, w_inc, w_ovf, w_unf;
    logic [PW-2:0]    w_norm;
    logic [MAN_W-1:0] w_frac;
    logic [MAN_W:0]   w_frac_rnd;
    logic [EXP_W+1:0] w_exp_rnd;

    assign w_p        = {r_hi, r_lo};
    assign w_msb      = w_p[PW-1];
    assign w_norm     = w_msb ? w_p[PW-2:0] : {w_p[PW-3:0], 1'b0};
    assign w_frac     = w_norm[PW-2 -: MAN_W];
    assign w_g        = w_norm[MAN_W];
    assign w_s        = |w_norm[MAN_W-1:0];
    assign w_inc      = w_g & (w_s | w_frac[0]);
    assign w_frac_rnd = {1'b0, w_frac} + {{MAN_W{1'b0}}, w_inc};
    assign w_exp_rnd  = r_exp + {{(EXP_W + 1){1'b0}}, w_msb} + {{(EXP_W + 1){1'b0}}, w_frac_rnd[MAN_W]};
    assign w_unf      = w_exp_rnd[EXP_W+1] | (w_exp_rnd == '0);
    assign w_ovf      = ~w_exp_rnd[EXP_W+1] & (w_exp_rnd >= EMAX_X);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) w_state_nxt = S_UNPACK;
            end
            S_UNPACK: w_state_nxt = w_special ? S_ROUND : S_MULT;
            S_MULT:   if (r_cnt == '0) w_state_nxt = S_ROUND;
            S_ROUND:  w_state_nxt = S_DONE;
            S_DONE: begin
                done_o      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= '0;  r_b <= '0;  r_hi <= '0;  r_lo <= '0;  r_ma <= '0;
            r_cnt <= '0;  r_exp <= '0;  r_sign <= 1'b0;
            r_special <= 1'b0;  r_spec_nan <= 1'b0;  r_spec_inf <= 1'b0;  r_spec_res <= '0;
            r_product <= '0;  r_nan <= 1'b0;  r_inf <= 1'b0;
            r_ovf <= 1'b0;  r_unf <= 1'b0;  r_inex <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start_i) begin
                    r_a <= a_i;
                    r_b <= b_i;
                end
                S_UNPACK: begin
                    r_sign     <= w_sign;
                    r_exp      <= {2'b00, w_ea} + {2'b00, w_eb} - BIAS_X;
                    r_special  <= w_special;
                    r_spec_nan <= w_is_nan;
                    r_spec_inf <= ~w_is_nan & w_is_inf;
                    r_spec_res <= w_is_nan ? QNAN :
                                  w_is_inf ? {w_sign, EMAX_F, {MAN_W{1'b0}}} : {w_sign, {(W - 1){1'b0}}};
                    r_hi       <= '0;
                    r_lo       <= {1'b1, w_fb};
                    r_ma       <= {1'b1, w_fa};
                    r_cnt      <= CW'(MAN_W);
                end
                S_MULT: begin
                    r_hi  <= w_sum[MAN_W+1:1];
                    r_lo  <= {w_sum[0], r_lo[MAN_W:1]};
                    r_cnt <= r_cnt - 1'b1;
                end
                S_ROUND: begin
                    r_nan <= 1'b0;  r_inf <= 1'b0;  r_ovf <= 1'b0;  r_unf <= 1'b0;
                    if (r_special) begin
                        r_product <= r_spec_res;
                        r_nan     <= r_spec_nan;
                        r_inf     <= r_spec_inf;
                        r_inex    <= 1'b0;
                    end else if (w_ovf) begin
                        r_product <= {r_sign, EMAX_F, {MAN_W{1'b0}}};
                        r_ovf     <= 1'b1;
                        r_inex    <= 1'b1;
                    end else if (w_unf) begin
                        r_product <= {r_sign, {(W - 1){1'b0}}};
                        r_unf     <= 1'b1;
                        r_inex    <= 1'b1;
                    end else begin
                        r_product <= {r_sign, w_exp_rnd[EXP_W-1:0], w_frac_rnd[MAN_W-1:0]};
                        r_inex    <= w_g | w_s;
                    end
                end
                default: ;
            endcase
        end
    end

    assign product_o   = r_product;
    assign nan_o       = r_nan;
    assign infinit_o   = r_inf;
    assign overflow_o  = r_ovf;
    assign underflow_o = r_unf;
    assign inexact_o   = r_inex;

endmodule

// File: tb/tb_fp_mult_seq.sv
// Bench for fp_mult_seq: default (8/23) and half (5/10) instances; scoreboard queues checked by done-driven monitors.
module tb_fp_mult_seq;

    localparam logic [4:0] F_NAN = 5'b10000, F_INF = 5'b01000, F_OVF = 5'b00100,
                           F_UNF = 5'b00010, F_INX = 5'b00001, F_NONE = 5'b00000;

    typedef struct {
        logic [31:0] prod;
        logic [4:0]  flags;
        int          start;
        int          lat;
        int          id;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        q32[$];
    exp_t        q16[$];

    logic        start32, busy32, done32, nan32, inf32, ovf32, unf32, inx32;
    logic [31:0] a32, b32, p32;
    logic        start16, busy16, done16, nan16, inf16, ovf16, unf16, inx16;
    logic [15:0] a16, b16, p16;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_mult_seq u_dut32 (
        .clk(clk), .rst_n(rst_n), .start_i(start32), .a_i(a32), .b_i(b32),
        .product_o(p32), .busy_o(busy32), .done_o(done32), .nan_o(nan32), .infinit_o(inf32),
        .overflow_o(ovf32), .underflow_o(unf32), .inexact_o(inx32)
    );

    fp_mult_seq #(.EXP_W(5), .MAN_W(10)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start_i(start16), .a_i(a16), .b_i(b16),
        .product_o(p16), .busy_o(busy16), .done_o(done16), .nan_o(nan16), .infinit_o(inf16),
        .overflow_o(ovf16), .underflow_o(unf16), .inexact_o(inx16)
    );

    task automatic chk(input string nm, input int id, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s id=%0d got=%0h exp=%0h", nm, id, got, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_checks++;
        n_errors++;
        $display("FAIL %s timed out at cycle %0d", nm, cyc);
    endtask

    // Bit-exact RNE reference for normal single-precision operands
    task automatic ref_mul(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] p, output logic [4:0] f);
        logic [47:0] prod;
        logic [46:0] nrm;
        logic [23:0] fr;
        logic        g, s, inc, sg;
        int          e;
        sg   = a[31] ^ b[31];
        prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e    = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (prod[47]) begin
            e++;
            nrm = prod[46:0];
        end else begin
            nrm = {prod[45:0], 1'b0};
        end
        fr  = {1'b0, nrm[46:24]};
        g   = nrm[23];
        s   = |nrm[22:0];
        inc = g & (s | fr[0]);
        fr  = fr + 24'(inc);
        if (fr[23]) e++;
        if (e >= 255) begin
            p = {sg, 8'hFF, 23'h0};
            f = F_OVF | F_INX;
        end else if (e <= 0) begin
            p = {sg, 31'h0};
            f = F_UNF | F_INX;
        end else begin
            p = {sg, e[7:0], fr[22:0]};
            f = (g | s) ? F_INX : F_NONE;
        end
    endtask

    task automatic on_done(input int dut, input logic [31:0] gp, input logic [4:0] gf, input int bcnt);
        exp_t e;
        if ((dut == 0 && q32.size() == 0) || (dut == 1 && q16.size() == 0)) begin
            chk(dut == 0 ? "unexpected_done32" : "unexpected_done16", -1, 32'd1, 32'd0);
        end else begin
            e = (dut == 0) ? q32.pop_front() : q16.pop_front();
            chk("product", e.id, gp, e.prod);
            chk("flags", e.id, 32'(gf), 32'(e.flags));
            chk("latency", e.id, cyc - e.start, e.lat);
            chk("busy_cycles", e.id, bcnt, e.lat + 1);
        end
    endtask

    int   bcnt32 = 0, bcnt16 = 0;
    logic idle_chk32 = 1'b0, idle_chk16 = 1'b0;

    always @(negedge clk) begin
        if (busy32) bcnt32++; else bcnt32 = 0;
        if (busy16) bcnt16++; else bcnt16 = 0;
        if (idle_chk32) begin
            idle_chk32 = 1'b0;
            chk("idle_after_done32", -1, {30'b0, busy32, done32}, 32'd0);
        end
        if (idle_chk16) begin
            idle_chk16 = 1'b0;
            chk("idle_after_done16", -1, {30'b0, busy16, done16}, 32'd0);
        end
        if (done32) begin
            on_done(0, p32, {nan32, inf32, ovf32, unf32, inx32}, bcnt32);
            idle_chk32 = 1'b1;
        end
        if (done16) begin
            on_done(1, {16'h0, p16}, {nan16, inf16, ovf16, unf16, inx16}, bcnt16);
            idle_chk16 = 1'b1;
        end
    end

    task automatic wait_idle(input int dut);
        int t = 0;
        while (((dut == 0) ? busy32 : busy16) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if ((dut == 0) ? busy32 : busy16) timeout("wait_idle");
    endtask

    task automatic issue(input int dut, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [4:0] f, input int lat, input int id);
        exp_t e;
        @(posedge clk); #1;
        wait_idle(dut);
        e = '{prod: p, flags: f, start: cyc + 1, lat: lat, id: id};
        if (dut == 0) begin
            a32 = a; b32 = b; start32 = 1'b1;
            q32.push_back(e);
        end else begin
            a16 = a[15:0]; b16 = b[15:0]; start16 = 1'b1;
            q16.push_back(e);
        end
        @(posedge clk); #1;
        start32 = 1'b0;
        start16 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rp;
        logic [4:0]  rf;
        int          s, t;
        rst_n = 1'b0;
        start32 = 1'b0; a32 = '0; b32 = '0;
        start16 = 1'b0; a16 = '0; b16 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_product32", 0, p32, 32'h0);
        chk("reset_ctl32", 0, {30'b0, busy32, done32}, 32'h0);
        chk("reset_flags32", 0, {27'b0, nan32, inf32, ovf32, unf32, inx32}, 32'h0);
        chk("reset_product16", 0, {16'h0, p16}, 32'h0);
        rst_n = 1'b1;

        issue(0, 32'h40400000, 32'h40200000, 32'h40F00000, F_NONE, 26, 1);
        issue(0, 32'h7F800000, 32'h00000000, 32'h7FC00000, F_NAN, 2, 2);
        issue(0, 32'hFF800000, 32'h40000000, 32'hFF800000, F_INF, 2, 3);
        issue(0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, F_NAN, 2, 4);
        issue(0, 32'hFF800000, 32'h7FC00000, 32'h7FC00000, F_NAN, 2, 5);
        issue(0, 32'h80000000, 32'h40000000, 32'h80000000, F_NONE, 2, 6);
        issue(0, 32'h00000001, 32'hC0000000, 32'h80000000, F_NONE, 2, 7);
        issue(0, 32'h7F000000, 32'h40000000, 32'h7F800000, F_OVF | F_INX, 26, 8);
        issue(0, 32'h00800000, 32'h00800000, 32'h00000000, F_UNF | F_INX, 26, 9);
        issue(0, 32'h3F800001, 32'h3F800001, 32'h3F800002, F_INX, 26, 10);
        ref_mul(32'h3F800001, 32'h3FFFFFFF, rp, rf);
        issue(0, 32'h3F800001, 32'h3FFFFFFF, rp, rf, 26, 11);
        issue(0, 32'h3FC00001, 32'h3FC00001, 32'h40100002, F_INX, 26, 12);
        issue(0, 32'h3F800001, 32'h3FC00000, 32'h3FC00002, F_INX, 26, 13);
        issue(0, 32'h3F800003, 32'h3FC00000, 32'h3FC00004, F_INX, 26, 14);
        issue(0, 32'h3F800001, 32'h3FFFFFFE, 32'h40000000, F_INX, 26, 15);
        issue(0, 32'hC0400000, 32'h40200000, 32'hC0F00000, F_NONE, 26, 16);
        issue(0, 32'hFF7FFFFF, 32'h3F800001, 32'hFF800000, F_OVF | F_INX, 26, 17);
        issue(0, 32'h00800000, 32'h3F800000, 32'h00800000, F_NONE, 26, 18);

        issue(1, 32'h3C00, 32'h4000, 32'h4000, F_NONE, 13, 30);
        issue(1, 32'h7BFF, 32'h4000, 32'h7C00, F_OVF | F_INX, 13, 31);
        issue(1, 32'h7C00, 32'h0000, 32'h7E00, F_NAN, 2, 32);
        issue(1, 32'h3C01, 32'h3C01, 32'h3C02, F_INX, 13, 33);

        // start held high with changing operands through the whole operation
        @(posedge clk); #1;
        wait_idle(0);
        a32 = 32'h3F800001; b32 = 32'h3FC00000; start32 = 1'b1;
        q32.push_back('{prod: 32'h3FC00002, flags: F_INX, start: cyc + 1, lat: 26, id: 40});
        repeat (28) begin
            @(posedge clk); #1;
            a32 = $urandom; b32 = $urandom;
        end
        start32 = 1'b0;

        // reset in the middle of MULT
        @(posedge clk); #1;
        wait_idle(0);
        t = 0;
        while ((q32.size() != 0 || q16.size() != 0 || busy16) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (q32.size() != 0 || q16.size() != 0) timeout("drain_before_reset");
        a32 = 32'h40400000; b32 = 32'h40200000; start32 = 1'b1;
        s = cyc + 1;
        @(posedge clk); #1;
        start32 = 1'b0;
        while (cyc < s + 10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_product32", 41, p32, 32'h0);
        chk("abort_ctl32", 41, {30'b0, busy32, done32}, 32'h0);
        chk("abort_flags32", 41, {27'b0, nan32, inf32, ovf32, unf32, inx32}, 32'h0);
        chk("abort_product16", 41, {16'h0, p16}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        issue(0, 32'h40400000, 32'h40200000, 32'h40F00000, F_NONE, 26, 42);

        t = 0;
        while ((q32.size() != 0 || q16.size() != 0) && t < 300) begin
            @(posedge clk);
            t++;
        end
        if (q32.size() != 0 || q16.size() != 0) timeout("final_drain");
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
